// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the R01 truth-table sweeper: FSM encoding, golden gate
// functions and the captured-row record handed downstream.
package truth_table_sweeper_pkg;

  localparam int N_ROWS = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef struct packed {
    logic [2:0] index;
    logic       sa;
    logic       sb;
    logic       err;
  } row_rsp_t;

  function automatic logic golden_sa(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

  function automatic logic golden_sb(input logic a, input logic b, input logic c);
    return (~a & b) | (c & ~b);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle delay for the sweeper: loadable 4-bit down-counter that flags the last
// cycle of the settle window.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  // Flagging at 1 rather than 0 gives exactly load_val cycles in SETTLE.
  assign expired = (cnt == 4'd1);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked stimulus/capture source for the R01 gates: sweeps a,b,c over all rows,
// samples sa/sb after a settle window and presents checked rows via ready/valid.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       sa,
  input  logic       sb,
  output logic       row_valid,
  input  logic       row_ready,
  output logic [2:0] row_index,
  output logic       row_sa,
  output logic       row_sb,
  output logic       row_err,
  output logic [3:0] err_count,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [2:0] state;
  logic [2:0] row;
  row_rsp_t   rsp;
  logic       launch, accept, last_row, expired, cap_err;

  assign launch   = start && (state == ST_IDLE || state == ST_DONE);
  assign accept   = (state == ST_PRESENT) && row_ready;
  assign last_row = (row == 3'(N_ROWS - 1));
  assign cap_err  = (sa != golden_sa(row[2], row[1])) ||
                    (sb != golden_sb(row[2], row[1], row[0]));

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (launch || (accept && !last_row)),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_SETTLE),
    .expired  (expired)
  );

  // row only moves on entry to SETTLE, so a,b,c are frozen while a sample is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      row       <= '0;
      rsp       <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state     <= ST_SETTLE;
          row       <= '0;
          err_count <= '0;
        end
        ST_SETTLE: if (expired) state <= ST_CAPTURE;
        ST_CAPTURE: begin
          rsp <= '{index: row, sa: sa, sb: sb, err: cap_err};
          if (cap_err && err_count != 4'hF) err_count <= err_count + 4'd1;
          state <= ST_PRESENT;
        end
        ST_PRESENT: if (row_ready) begin
          if (last_row) state <= ST_DONE;
          else begin
            row   <= row + 3'd1;
            state <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c}  = row;
  assign row_valid  = (state == ST_PRESENT);
  assign row_index  = rsp.index;
  assign row_sa     = rsp.sa;
  assign row_sb     = rsp.sb;
  assign row_err    = rsp.err;
  assign busy       = (state == ST_SETTLE) || (state == ST_CAPTURE) || (state == ST_PRESENT);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: behavioural gates with fault injection, random
// back-pressure and a truth-table model of the expected presented rows.
module tb_truth_table_sweeper;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst, start, row_ready;
  logic       a, b, c, sa, sb;
  logic       row_valid, row_sa, row_sb, row_err, busy, done;
  logic [2:0] row_index;
  logic [3:0] err_count;

  logic [7:0] flip_sa, flip_sb;
  logic       stuck_sb;
  logic [2:0] abc;
  logic [7:0] tbl_sa, tbl_sb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Gate stand-ins (XNOR mux and NAND network) with per-row fault injection.
  assign abc = {a, b, c};
  assign sa  = (a ~^ b) ^ flip_sa[abc];
  assign sb  = stuck_sb ? 1'b0 : (((~a & b) | (c & ~b)) ^ flip_sb[abc]);

  truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .sa(sa), .sb(sb),
    .row_valid(row_valid), .row_ready(row_ready), .row_index(row_index),
    .row_sa(row_sa), .row_sb(row_sb), .row_err(row_err), .err_count(err_count),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Model of what the gates deliver for a row and whether that differs from golden.
  function automatic logic [2:0] model_row(input int r);
    logic osa, osb;
    osa = tbl_sa[r] ^ flip_sa[r];
    osb = stuck_sb ? 1'b0 : (tbl_sb[r] ^ flip_sb[r]);
    return {osa, osb, (osa != tbl_sa[r]) || (osb != tbl_sb[r])};
  endfunction

  // mode 0: ready high; 1: random ready; 2: stall row 3 for 5 clocks.
  task automatic sweep(input int mode, input string name);
    int idx = 0, cyc = 0, errs = 0, stall = 0;
    logic have_prev = 1'b0;
    logic [5:0] prev = '0;
    logic [2:0] m;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, " start_abc"}, 32'(abc), 32'd0);
    check({name, " start_errcnt"}, 32'(err_count), 32'd0);
    check({name, " start_busy"}, 32'(busy), 32'd1);
    while (cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      check({name, " abc"}, 32'(abc), 32'(idx));
      case (mode)
        0: row_ready = 1'b1;
        1: row_ready = ($urandom_range(0, 3) != 0);
        default: row_ready = !(idx == 3 && stall < 5);
      endcase
      if (row_valid) begin
        m = model_row(idx);
        if (have_prev)
          check({name, " stable"}, 32'({row_index, row_sa, row_sb, row_err}), 32'(prev));
        else begin
          check({name, " index"}, 32'(row_index), 32'(idx));
          check({name, " sa_sb_err"}, 32'({row_sa, row_sb, row_err}), 32'(m));
          check({name, " errcnt"}, 32'(err_count), 32'(sat15(errs + int'(m[0]))));
        end
        // Start while busy, and coincident with the final handshake: both ignored.
        start = (idx == 2) || (idx == 7 && row_ready);
        if (row_ready) begin
          errs += int'(m[0]);
          idx++;
          have_prev = 1'b0;
        end else begin
          if (idx == 3) stall++;
          have_prev = 1'b1;
          prev = {row_index, row_sa, row_sb, row_err};
        end
      end
      @(posedge clk);
      cyc++;
    end
    check({name, " no_timeout"}, 32'(cyc < 2000), 32'd1);
    check({name, " rows"}, 32'(idx), 32'd8);
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " busy_done"}, 32'(busy), 32'd0);
    check({name, " errcnt_done"}, 32'(err_count), 32'(sat15(errs)));
    check({name, " abc_done"}, 32'(abc), 32'd7);
    if (mode == 0) check({name, " sweep_clocks"}, 32'(cyc), 32'(8 * (S + 2)));
    if (mode == 2) check({name, " stall_len"}, 32'(stall), 32'd5);
    repeat (3) @(negedge clk);
    check({name, " done_held"}, 32'({done, busy, row_valid}), 32'b100);
  endtask

  task automatic reset_mid_sweep();
    int guard = 0;
    row_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!(row_valid && row_index == 3'd4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst wait_row4", 32'(guard < 200), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst outputs", 32'({row_valid, row_index, row_sa, row_sb, row_err, busy, done}), 32'd0);
    check("rst abc", 32'(abc), 32'd0);
    check("rst errcnt", 32'(err_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    guard = 0;
    repeat (40) begin
      @(negedge clk);
      if (row_valid || busy || done) guard++;
    end
    check("rst quiet", 32'(guard), 32'd0);
  endtask

  initial begin
    tbl_sa = 8'b1100_0011;
    tbl_sb = 8'b0010_1110;
    rst = 1'b1; start = 1'b0; row_ready = 1'b0;
    flip_sa = '0; flip_sb = '0; stuck_sb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({row_valid, row_index, row_sa, row_sb, row_err, busy, done}), 32'd0);
    check("reset abc_errcnt", 32'({abc, err_count}), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle quiet", 32'({busy, done, row_valid}), 32'd0);

    sweep(0, "nominal");
    stuck_sb = 1'b1;
    sweep(0, "stuck_sb");
    stuck_sb = 1'b0;
    sweep(2, "backpressure");
    flip_sa = 8'hFF; flip_sb = 8'hFF;
    sweep(0, "invert_1");
    sweep(0, "invert_2");
    repeat (6) begin
      flip_sa = 8'($urandom_range(0, 255));
      flip_sb = 8'($urandom_range(0, 255));
      stuck_sb = ($urandom_range(0, 3) == 0);
      sweep(1, "random");
    end
    flip_sa = 8'h5A; flip_sb = '0; stuck_sb = 1'b0;
    reset_mid_sweep();
    flip_sa = '0;
    sweep(0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
